// File: rtl/mult_hilo_unit.sv
// HI/LO multiply sequencer: issues operands to an external combinational
// multiplier, waits LATENCY cycles, then captures the 64-bit product into HI/LO.
module mult_hilo_unit #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        mul_sign,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_res,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (hi_we) hi_d = wdata;
    if (lo_we) lo_d = wdata;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sign_d  = sign;
            a_d     = op_a;
            b_d     = op_b;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            // product overrides any same-edge direct write
            hi_d    = mul_res[63:32];
            lo_d    = mul_res[31:0];
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == CALC);
      done_q  <= (state_d == DONE);
    end
  end

  assign mul_sign = sign_q;
  assign mul_x    = a_q;
  assign mul_y    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: vector table, random products against
// an arithmetic model, and hand-written sequences for flush/reset/collision cases.
module tb_mult_hilo_unit;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, sign, flush, hi_we, lo_we;
  logic [31:0] op_a, op_b, wdata;
  logic        mul_sign;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_res;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_hilo_unit #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .op_a(op_a), .op_b(op_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .mul_sign(mul_sign), .mul_x(mul_x), .mul_y(mul_y), .mul_res(mul_res),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // external combinational multiplier
  assign mul_res = prod(mul_sign, mul_x, mul_y);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; sign = 0; op_a = 0; op_b = 0; flush = 0;
    hi_we = 0; lo_we = 0; wdata = 0; rst = 0;
  endtask

  // full multiply with busy/done timing checks; leaves unit in IDLE
  task automatic run_mult(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    start = 1; sign = s; op_a = a; op_b = b;
    tick();
    start = 0; op_a = ~a; op_b = ~b;
    for (int i = 0; i < LAT; i++) begin
      check({name, " busy"}, {63'd0, busy}, 64'd1);
      check({name, " done_early"}, {63'd0, done}, 64'd0);
      tick();
    end
    check({name, " done"}, {63'd0, done}, 64'd1);
    check({name, " busy_off"}, {63'd0, busy}, 64'd0);
    check({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({name, " lo"}, {32'd0, lo}, {32'd0, el});
    tick();
    check({name, " done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int dones;
    logic [63:0] p;
    logic s;
    logic [31:0] a, b;

    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[3] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tbl[5] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tbl[6] = '{1'b0, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006};

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    check("rst mul_x", {32'd0, mul_x}, 64'd0);
    check("rst mul_sign", {63'd0, mul_sign}, 64'd0);

    for (int i = 0; i < 7; i++)
      run_mult($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      p = s ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) : {32'd0, a} * {32'd0, b};
      run_mult($sformatf("rnd%0d", i), s, a, b, p[63:32], p[31:0]);
    end

    // back-to-back with start held; operands change during CALC and must be ignored
    start = 1; sign = 0; op_a = 32'h12345678; op_b = 32'h10;
    tick();
    op_a = 3; op_b = 4;
    for (int i = 0; i < LAT; i++) begin
      check("b2b mul_x hold", {32'd0, mul_x}, 64'h12345678);
      tick();
    end
    check("b2b done1", {63'd0, done}, 64'd1);
    check("b2b hi1", {32'd0, hi}, 64'h1);
    check("b2b lo1", {32'd0, lo}, 64'h23456780);
    tick();
    start = 0;
    check("b2b no_bubble", {63'd0, busy}, 64'd1);
    check("b2b mul_x2", {32'd0, mul_x}, 64'd3);
    for (int i = 0; i < LAT; i++) tick();
    check("b2b done2", {63'd0, done}, 64'd1);
    check("b2b hi2", {32'd0, hi}, 64'd0);
    check("b2b lo2", {32'd0, lo}, 64'd12);
    tick();

    // flush one cycle after accept
    hi_we = 1; lo_we = 1; wdata = 32'hAAAAAAAA;
    tick();
    hi_we = 0; lo_we = 0;
    start = 1; sign = 0; op_a = 7; op_b = 9;
    tick();
    start = 0; flush = 1;
    tick();
    flush = 0;
    check("flush busy", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (done) dones++;
      tick();
    end
    check("flush no_done", dones, 0);
    check("flush hi", {32'd0, hi}, 64'hAAAAAAAA);
    check("flush lo", {32'd0, lo}, 64'hAAAAAAAA);

    // flush beats simultaneous start
    start = 1; flush = 1; op_a = 5; op_b = 5;
    tick();
    start = 0; flush = 0;
    check("flush_vs_start busy", {63'd0, busy}, 64'd0);

    // reset mid-CALC
    hi_we = 1; lo_we = 1; wdata = 32'hAAAAAAAA;
    tick();
    hi_we = 0; lo_we = 0;
    start = 1; op_a = 7; op_b = 9;
    tick();
    start = 0; rst = 1;
    tick();
    rst = 0;
    check("rstmid busy", {63'd0, busy}, 64'd0);
    check("rstmid hi", {32'd0, hi}, 64'd0);
    check("rstmid lo", {32'd0, lo}, 64'd0);
    check("rstmid mul_x", {32'd0, mul_x}, 64'd0);
    dones = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (done) dones++;
      tick();
    end
    check("rstmid no_done", dones, 0);
    check("rstmid hi_after", {32'd0, hi}, 64'd0);

    // direct write on capture edge loses to product
    start = 1; sign = 0; op_a = 2; op_b = 3;
    tick();
    start = 0;
    for (int i = 0; i < LAT - 1; i++) tick();
    hi_we = 1; wdata = 32'h55555555;
    tick();
    hi_we = 0;
    check("coll done", {63'd0, done}, 64'd1);
    check("coll hi", {32'd0, hi}, 64'd0);
    check("coll lo", {32'd0, lo}, 64'd6);
    tick();
    hi_we = 1;
    tick();
    hi_we = 0;
    check("idle write hi", {32'd0, hi}, 64'h55555555);
    check("idle write lo", {32'd0, lo}, 64'd6);

    // accept with simultaneous direct write; product overwrites later
    start = 1; sign = 0; op_a = 32'h10000; op_b = 32'h30000; hi_we = 1; lo_we = 1; wdata = 32'h1234;
    tick();
    start = 0; hi_we = 0; lo_we = 0;
    check("acc_wr hi", {32'd0, hi}, 64'h1234);
    check("acc_wr lo", {32'd0, lo}, 64'h1234);
    for (int i = 0; i < LAT; i++) tick();
    check("acc_wr hi_final", {32'd0, hi}, 64'h3);
    check("acc_wr lo_final", {32'd0, lo}, 64'h0);
    tick();

    // start pulsed while busy is ignored
    start = 1; sign = 1; op_a = 11; op_b = 13;
    tick();
    start = 1; op_a = 99; op_b = 99;
    dones = 0;
    for (int i = 0; i < LAT; i++) begin
      check("busy_start mul_x", {32'd0, mul_x}, 64'd11);
      check("busy_start mul_y", {32'd0, mul_y}, 64'd13);
      start = (i == 0);
      tick();
      start = 0;
    end
    for (int i = 0; i < LAT + 4; i++) begin
      if (done) dones++;
      tick();
    end
    check("busy_start one_done", dones, 1);
    check("busy_start lo", {32'd0, lo}, 64'd143);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_hilo_unit.md
MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

Interface
REQ-001 SHALL have parameter: LATENCY, 2, cycles spent in CALC before the HI/LO update; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  multiply request, sampled every cycle.
REQ-005 SHALL have port: sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
REQ-006 SHALL have port: op_a  input  32  multiplicand, sampled with start.
REQ-007 SHALL have port: op_b  input  32  multiplier, sampled with start.
REQ-008 SHALL have port: flush  input  1  cancels any in-flight multiply.
REQ-009 SHALL have port: hi_we  input  1  direct HI write (MTHI).
REQ-010 SHALL have port: lo_we  input  1  direct LO write (MTLO).
REQ-011 SHALL have port: wdata  input  32  data for hi_we and lo_we.
REQ-012 SHALL have port: mul_sign  output  1  to the combinational multiplier's sign input.
REQ-013 SHALL have port: mul_x  output  32  to the multiplier's X operand.
REQ-014 SHALL have port: mul_y  output  32  to the multiplier's Y operand.
REQ-015 SHALL have port: mul_res  input  64  product from the multiplier.
REQ-016 SHALL have port: busy  output  1  high while a multiply is in flight.
REQ-017 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port: hi  output  32  HI register.
REQ-019 SHALL have port: lo  output  32  LO register.

Function
REQ-020 SHALL implement the FSM states IDLE, CALC and DONE, with a 3-bit down-counter cnt.
REQ-021 SHALL accept a request when start=1, flush=0 and state is IDLE or DONE.
- On accept: latch sign/op_a/op_b into operand registers, set cnt=LATENCY-1, go to CALC.
REQ-022 SHALL drive mul_sign, mul_x and mul_y from the operand registers only, never straight from the inputs; they hold stable throughout CALC.
REQ-023 SHALL, in CALC with cnt!=0, decrement cnt each cycle.
- In CALC with cnt==0: hi<=mul_res[63:32], lo<=mul_res[31:0], go to DONE.
REQ-024 SHALL assert busy exactly when state==CALC.
- Accept in cycle k gives busy high in cycles k+1..k+LATENCY.
- New HI/LO and done=1 are visible in cycle k+LATENCY+1.
REQ-025 SHALL assert done only when state==DONE.
- DONE lasts one cycle, then goes to IDLE, or to CALC if a new request is accepted in that cycle (back-to-back issue, no bubble).
REQ-026 SHALL ignore start while busy=1; no queuing.
REQ-027 SHALL, on flush=1 in any state, go to IDLE with no HI/LO update from the multiply and no done pulse; flush beats a simultaneous start.
REQ-028 SHALL apply hi_we/lo_we on the next edge in any state; both may fire together.
- On the CALC capture edge, the multiply result beats a direct write to the same register.
REQ-029 SHALL, when start is accepted together with hi_we/lo_we, apply the direct write at that edge; the multiply overwrites HI/LO later.
REQ-030 SHALL leave HI/LO untouched by mul_res outside the capture edge.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=IDLE, cnt=0, operand registers=0, hi=0, lo=0, busy=0, done=0.
REQ-032 SHALL give rst priority over flush, start and hi_we/lo_we.
REQ-033 SHALL, on rst mid-CALC, abort the multiply with no later HI/LO update or done.

Verification
REQ-034 SHALL cover unsigned full-scale: sign=0, a=b=0xFFFFFFFF, LATENCY=2 -> busy cycles k+1..k+2, done at k+3, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL cover signed mixed sign: sign=1, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; also a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-036 SHALL cover back-to-back issue: start held, unsigned 0x12345678*0x10 then 3*4 -> first done: hi=0x00000001, lo=0x23456780; second accept in the DONE cycle; second done LATENCY+1 cycles later: hi=0, lo=12.
REQ-037 SHALL cover flush and reset mid-CALC: hi=lo=0xAAAAAAAA preloaded, then flush one cycle after accept -> no done, HI/LO stay 0xAAAAAAAA; repeat with rst -> hi=lo=0, busy=0.
REQ-038 SHALL cover the write/capture collision: hi_we=1, wdata=0x55555555 on the capture edge of 2*3 -> hi=0, lo=6; the same write in IDLE -> hi=0x55555555.
REQ-039 SHALL cover start while busy: start pulsed in CALC -> ignored; operand outputs unchanged; exactly one done.
